// File: rtl/icmp_rx_parser.sv
// ICMP receive parser: extracts header fields, buffers echo payload, reports or drops each frame.
// Optional build macro ICMP_RX_CSUM_CHECK_EN enables on-the-fly one's-complement checksum checking.
module icmp_rx_parser #(
   parameter int P_PLD_DEPTH = 64,
   parameter int P_PLD_AW    = 6,
   parameter int P_CNT_W     = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [7:0]          i_icmp_data,
   input  logic [15:0]         i_icmp_len,
   input  logic                i_icmp_last,
   input  logic                i_icmp_valid,
   input  logic                i_busy,
   input  logic [P_PLD_AW-1:0] i_pld_rd_addr,
   output logic [7:0]          o_pld_rd_data,
   output logic                o_req_valid,
   output logic [7:0]          o_req_type,
   output logic [7:0]          o_req_code,
   output logic [15:0]         o_req_id,
   output logic [15:0]         o_req_seq,
   output logic [15:0]         o_req_len,
   output logic                o_req_trunc,
   output logic                o_drop,
   output logic [P_CNT_W-1:0]  o_frame_cnt,
   output logic [P_CNT_W-1:0]  o_drop_cnt
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_HDR     = 3'd1;
   localparam logic [2:0] S_PLD     = 3'd2;
   localparam logic [2:0] S_DISCARD = 3'd3;
   localparam logic [2:0] S_REPORT  = 3'd4;
   localparam logic [15:0] DEPTH16  = 16'(P_PLD_DEPTH);

   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d, len_q, len_d, id_q, id_d, seq_q, seq_d;
   logic [7:0]  type_q, type_d, code_q, code_d;
   logic        trunc_q, trunc_d;
   logic        done, disc_done, we, acc, sum_ok, start;
   logic [15:0] pidx, rlen;
   logic [P_PLD_AW-1:0] waddr;
   logic [7:0]  ram [P_PLD_DEPTH];

   logic                req_valid_q, drop_q, req_trunc_q;
   logic [7:0]          req_type_q, req_code_q, rd_data_q;
   logic [15:0]         req_id_q, req_seq_q, req_len_q;
   logic [P_CNT_W-1:0]  frame_cnt_q, drop_cnt_q;

   assign start = (state_q == S_IDLE) || (state_q == S_REPORT);
   assign pidx  = cnt_q - 16'd8;
   assign waddr = pidx[P_PLD_AW-1:0];
   assign rlen  = cnt_d - 16'd8;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      type_d    = type_q;
      code_d    = code_q;
      id_d      = id_q;
      seq_d     = seq_q;
      trunc_d   = trunc_q;
      we        = 1'b0;
      done      = 1'b0;
      disc_done = 1'b0;
      case (state_q)
         S_IDLE, S_REPORT: begin
            state_d = S_IDLE;
            if (i_icmp_valid) begin
               if (i_busy) begin
                  if (i_icmp_last) disc_done = 1'b1;
                  else             state_d   = S_DISCARD;
               end else begin
                  cnt_d   = 16'd1;
                  len_d   = i_icmp_len;
                  type_d  = i_icmp_data;
                  trunc_d = 1'b0;
                  done    = i_icmp_last;
                  state_d = i_icmp_last ? S_REPORT : S_HDR;
               end
            end
         end
         S_HDR: if (i_icmp_valid) begin
            cnt_d = cnt_q + 16'd1;
            // bytes 2-3 (checksum field) are consumed only by the optional running sum
            case (cnt_q[2:0])
               3'd1:    code_d = i_icmp_data;
               3'd4:    id_d   = {i_icmp_data, id_q[7:0]};
               3'd5:    id_d   = {id_q[15:8], i_icmp_data};
               3'd6:    seq_d  = {i_icmp_data, seq_q[7:0]};
               3'd7:    seq_d  = {seq_q[15:8], i_icmp_data};
               default: ;
            endcase
            if (i_icmp_last) begin
               state_d = S_REPORT;
               done    = 1'b1;
            end else if (cnt_q[2:0] == 3'd7) begin
               state_d = S_PLD;
            end
         end
         S_PLD: if (i_icmp_valid) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            if (pidx < DEPTH16) we      = 1'b1;
            else                trunc_d = 1'b1;
            if (i_icmp_last) begin
               state_d = S_REPORT;
               done    = 1'b1;
            end
         end
         S_DISCARD: if (i_icmp_valid && i_icmp_last) begin
            state_d   = S_IDLE;
            disc_done = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef ICMP_RX_CSUM_CHECK_EN
   logic [15:0] sum_q, sum_d, sum_base, sum_term;
   logic        sum_en;

   function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   // even byte index is the high half of a word; odd final byte is implicitly zero-padded
   always_comb begin
      sum_en   = i_icmp_valid && ((state_q == S_HDR) || (state_q == S_PLD) || (start && !i_busy));
      sum_base = start ? 16'd0 : sum_q;
      sum_term = (start || !cnt_q[0]) ? {i_icmp_data, 8'd0} : {8'd0, i_icmp_data};
      sum_d    = sum_en ? oc_add(sum_base, sum_term) : sum_q;
   end

   assign sum_ok = (sum_d == 16'hFFFF);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) sum_q <= 16'd0;
      else       sum_q <= sum_d;
   end
`else
   assign sum_ok = 1'b1;
`endif

   assign acc = ((type_d == 8'd0) || (type_d == 8'd8)) && (cnt_d == len_d) &&
                (cnt_d >= 16'd8) && sum_ok;

   // verdict is formed on the last beat so the pulse lands in the S_REPORT cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 16'd0;
         len_q       <= 16'd0;
         type_q      <= 8'd0;
         code_q      <= 8'd0;
         id_q        <= 16'd0;
         seq_q       <= 16'd0;
         trunc_q     <= 1'b0;
         req_valid_q <= 1'b0;
         drop_q      <= 1'b0;
         req_type_q  <= 8'd0;
         req_code_q  <= 8'd0;
         req_id_q    <= 16'd0;
         req_seq_q   <= 16'd0;
         req_len_q   <= 16'd0;
         req_trunc_q <= 1'b0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
         rd_data_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         type_q      <= type_d;
         code_q      <= code_d;
         id_q        <= id_d;
         seq_q       <= seq_d;
         trunc_q     <= trunc_d;
         rd_data_q   <= ram[i_pld_rd_addr];
         req_valid_q <= done && acc;
         drop_q      <= (done && !acc) || disc_done;
         if (done && acc) begin
            req_type_q  <= type_d;
            req_code_q  <= code_d;
            req_id_q    <= id_d;
            req_seq_q   <= seq_d;
            req_len_q   <= (rlen > DEPTH16) ? DEPTH16 : rlen;
            req_trunc_q <= trunc_d;
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
         if ((done && !acc) || disc_done) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (we) ram[waddr] <= i_icmp_data;
   end

   assign o_pld_rd_data = rd_data_q;
   assign o_req_valid   = req_valid_q;
   assign o_req_type    = req_type_q;
   assign o_req_code    = req_code_q;
   assign o_req_id      = req_id_q;
   assign o_req_seq     = req_seq_q;
   assign o_req_len     = req_len_q;
   assign o_req_trunc   = req_trunc_q;
   assign o_drop        = drop_q;
   assign o_frame_cnt   = frame_cnt_q;
   assign o_drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_icmp_rx_parser.sv
// Directed bench for icmp_rx_parser: echo accept, drops, runts, truncation, busy, gaps, reset.
module tb_icmp_rx_parser;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  i_icmp_data;
   logic [15:0] i_icmp_len;
   logic        i_icmp_last, i_icmp_valid, i_busy;
   logic [5:0]  i_pld_rd_addr;
   logic [7:0]  o_pld_rd_data, o_req_type, o_req_code;
   logic        o_req_valid, o_req_trunc, o_drop;
   logic [15:0] o_req_id, o_req_seq, o_req_len, o_frame_cnt, o_drop_cnt;

`ifdef ICMP_RX_CSUM_CHECK_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   icmp_rx_parser #(.P_PLD_DEPTH(64), .P_PLD_AW(6), .P_CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_icmp_data(i_icmp_data), .i_icmp_len(i_icmp_len),
      .i_icmp_last(i_icmp_last), .i_icmp_valid(i_icmp_valid), .i_busy(i_busy),
      .i_pld_rd_addr(i_pld_rd_addr), .o_pld_rd_data(o_pld_rd_data),
      .o_req_valid(o_req_valid), .o_req_type(o_req_type), .o_req_code(o_req_code),
      .o_req_id(o_req_id), .o_req_seq(o_req_seq), .o_req_len(o_req_len),
      .o_req_trunc(o_req_trunc), .o_drop(o_drop), .o_frame_cnt(o_frame_cnt),
      .o_drop_cnt(o_drop_cnt)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0, n_bad = 0;
   int         ef, ed;
   logic [7:0] frm [0:127];
   logic       pulse_req, pulse_drop;
   logic [7:0] exp_code;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_a();
      logic [7:0] a [0:11] = '{8'h08, 8'h00, 8'hE0, 8'hE8, 8'h01, 8'h01, 8'h06, 8'h06,
                               8'h08, 8'h08, 8'h08, 8'h08};
      for (int i = 0; i < 12; i++) frm[i] = a[i];
   endtask

   task automatic load_b();
      logic [7:0] b [0:11] = '{8'h08, 8'h01, 8'h02, 8'h03, 8'h01, 8'h01, 8'h06, 8'h06,
                               8'h08, 8'h08, 8'h08, 8'h08};
      for (int i = 0; i < 12; i++) frm[i] = b[i];
   endtask

   task automatic fix_csum(input int n);
      logic [16:0] s;
      logic [15:0] w;
      frm[2] = 8'h00;
      frm[3] = 8'h00;
      s = 17'd0;
      for (int i = 0; i < n; i += 2) begin
         w = {frm[i], (i + 1 < n) ? frm[i+1] : 8'h00};
         s = {1'b0, s[15:0]} + {1'b0, w};
         s = {1'b0, s[15:0] + {15'd0, s[16]}};
      end
      {frm[2], frm[3]} = ~s[15:0];
   endtask

   // drives n bytes; leaves the report-cycle pulses in pulse_req/pulse_drop
   task automatic send_frame(input int n, input logic [15:0] len, input bit gaps,
                             input bit busy0, input bit tog);
      for (int i = 0; i < n; i++) begin
         i_icmp_valid = 1'b1;
         i_icmp_data  = frm[i];
         i_icmp_last  = (i == n - 1);
         i_icmp_len   = len;
         i_busy       = (i == 0 || !tog) ? busy0 : (busy0 ^ i[0]);
         @(posedge clk); #1;
         if (gaps && i != n - 1) begin
            i_icmp_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      i_icmp_valid = 1'b0;
      i_icmp_last  = 1'b0;
      i_busy       = 1'b0;
      pulse_req    = o_req_valid;
      pulse_drop   = o_drop;
   endtask

   task automatic rd_chk(input string tag, input int addr, input logic [7:0] exp);
      i_pld_rd_addr = 6'(addr);
      @(posedge clk); #1;
      chk(tag, 32'(o_pld_rd_data), 32'(exp));
   endtask

   initial begin
      logic p1r, p1d;
      rst = 1'b1;
      i_icmp_data = 8'd0; i_icmp_len = 16'd0; i_icmp_last = 1'b0;
      i_icmp_valid = 1'b0; i_busy = 1'b0; i_pld_rd_addr = 6'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_valid", 32'(o_req_valid), 32'd0);
      chk("rst_drop", 32'(o_drop), 32'd0);
      chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
      chk("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
      chk("rst_req_len", 32'(o_req_len), 32'd0);
      chk("rst_rd_data", 32'(o_pld_rd_data), 32'd0);
      rst = 1'b0;
      ef = 0; ed = 0;

      // 1: basic echo request
      load_a();
      send_frame(12, 16'd12, 1'b0, 1'b0, 1'b0);
      ef++;
      chk("t1_req_pulse", 32'(pulse_req), 32'd1);
      chk("t1_drop_pulse", 32'(pulse_drop), 32'd0);
      chk("t1_type", 32'(o_req_type), 32'h08);
      chk("t1_code", 32'(o_req_code), 32'h00);
      chk("t1_id", 32'(o_req_id), 32'h0101);
      chk("t1_seq", 32'(o_req_seq), 32'h0606);
      chk("t1_len", 32'(o_req_len), 32'd4);
      chk("t1_trunc", 32'(o_req_trunc), 32'd0);
      chk("t1_frame_cnt", 32'(o_frame_cnt), 32'(ef));
      @(posedge clk); #1;
      chk("t1_one_cycle", 32'(o_req_valid), 32'd0);
      for (int a = 0; a < 4; a++) rd_chk("t1_ram", a, 8'h08);

      // 2: bad-checksum frame twice back to back
      load_b();
      send_frame(12, 16'd12, 1'b0, 1'b0, 1'b0);
      p1r = pulse_req; p1d = pulse_drop;
      send_frame(12, 16'd12, 1'b0, 1'b0, 1'b0);
      ef += CSUM_EN ? 0 : 2;
      ed += CSUM_EN ? 2 : 0;
      exp_code = CSUM_EN ? 8'h00 : 8'h01;
      chk("t2_req1", 32'(p1r), 32'(!CSUM_EN));
      chk("t2_drop1", 32'(p1d), 32'(CSUM_EN));
      chk("t2_req2", 32'(pulse_req), 32'(!CSUM_EN));
      chk("t2_drop2", 32'(pulse_drop), 32'(CSUM_EN));
      chk("t2_code", 32'(o_req_code), 32'(exp_code));
      chk("t2_frame_cnt", 32'(o_frame_cnt), 32'(ef));
      chk("t2_drop_cnt", 32'(o_drop_cnt), 32'(ed));

      // 3: unsupported type, then length mismatch
      load_a(); frm[0] = 8'h03;
      send_frame(12, 16'd12, 1'b0, 1'b0, 1'b0);
      ed++;
      chk("t3_type_drop", 32'(pulse_drop), 32'd1);
      chk("t3_type_noreq", 32'(pulse_req), 32'd0);
      chk("t3_type_held", 32'(o_req_type), 32'h08);
      chk("t3_code_held", 32'(o_req_code), 32'(exp_code));
      load_a();
      send_frame(12, 16'd14, 1'b0, 1'b0, 1'b0);
      ed++;
      chk("t3_len_drop", 32'(pulse_drop), 32'd1);
      chk("t3_drop_cnt", 32'(o_drop_cnt), 32'(ed));

      // 4: runt followed by a good frame
      load_a();
      send_frame(5, 16'd12, 1'b0, 1'b0, 1'b0);
      ed++;
      chk("t4_runt_drop", 32'(pulse_drop), 32'd1);
      send_frame(12, 16'd12, 1'b0, 1'b0, 1'b0);
      ef++;
      chk("t4_req", 32'(pulse_req), 32'd1);
      chk("t4_code", 32'(o_req_code), 32'h00);
      chk("t4_frame_cnt", 32'(o_frame_cnt), 32'(ef));
      chk("t4_drop_cnt", 32'(o_drop_cnt), 32'(ed));

      // 5: 100-byte payload truncated to 64, then busy drop
      frm[0] = 8'h08; frm[1] = 8'h00; frm[4] = 8'h12; frm[5] = 8'h34;
      frm[6] = 8'h00; frm[7] = 8'h42;
      for (int i = 0; i < 100; i++) frm[8+i] = 8'(i);
      fix_csum(108);
      send_frame(108, 16'd108, 1'b0, 1'b0, 1'b0);
      ef++;
      chk("t5_req", 32'(pulse_req), 32'd1);
      chk("t5_len", 32'(o_req_len), 32'd64);
      chk("t5_trunc", 32'(o_req_trunc), 32'd1);
      chk("t5_id", 32'(o_req_id), 32'h1234);
      chk("t5_seq", 32'(o_req_seq), 32'h0042);
      rd_chk("t5_ram0", 0, 8'd0);
      rd_chk("t5_ram40", 40, 8'd40);
      rd_chk("t5_ram63", 63, 8'd63);
      load_a();
      send_frame(12, 16'd12, 1'b0, 1'b1, 1'b1);
      ed++;
      chk("t5_busy_drop", 32'(pulse_drop), 32'd1);
      chk("t5_busy_noreq", 32'(pulse_req), 32'd0);
      chk("t5_busy_frame_cnt", 32'(o_frame_cnt), 32'(ef));
      chk("t5_busy_drop_cnt", 32'(o_drop_cnt), 32'(ed));
      chk("t5_busy_len_held", 32'(o_req_len), 32'd64);
      rd_chk("t5_ram1_kept", 1, 8'd1);

      // 6: valid gaps, then reset mid-frame
      load_a();
      send_frame(12, 16'd12, 1'b1, 1'b0, 1'b0);
      ef++;
      chk("t6_gap_req", 32'(pulse_req), 32'd1);
      chk("t6_gap_id", 32'(o_req_id), 32'h0101);
      chk("t6_gap_seq", 32'(o_req_seq), 32'h0606);
      chk("t6_gap_len", 32'(o_req_len), 32'd4);
      chk("t6_gap_trunc", 32'(o_req_trunc), 32'd0);
      chk("t6_gap_frame_cnt", 32'(o_frame_cnt), 32'(ef));
      for (int i = 0; i < 6; i++) begin
         i_icmp_valid = 1'b1; i_icmp_data = frm[i]; i_icmp_len = 16'd12; i_icmp_last = 1'b0;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      i_icmp_valid = 1'b0;
      @(posedge clk); #1;
      chk("t6_rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
      chk("t6_rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
      chk("t6_rst_type", 32'(o_req_type), 32'd0);
      chk("t6_rst_id", 32'(o_req_id), 32'd0);
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("t6_rst_nopulse", 32'({o_req_valid, o_drop}), 32'd0);
      end
      send_frame(12, 16'd12, 1'b0, 1'b0, 1'b0);
      chk("t6_post_req", 32'(pulse_req), 32'd1);
      chk("t6_post_frame_cnt", 32'(o_frame_cnt), 32'd1);
      chk("t6_post_drop_cnt", 32'(o_drop_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
